board_store: RTL

BOARD_STORE -- requirements
Module: board_store

---
 rtl/board_store_pkg.sv | 51 +++++
 rtl/board_store_lfsr16.sv | 31 +++
 rtl/board_store.sv | 99 +++++++++
 3 files changed

// File: rtl/board_store_pkg.sv
// Shared encodings for the board: piece fields, FSM state codes, default LFSR
// seed and the canonical (pre-shuffle) layout used by game logic and display.
package board_store_pkg;

  typedef enum logic [2:0] {
    PT_NONE    = 3'd0,
    PT_SOLDIER = 3'd1,
    PT_CANNON  = 3'd2,
    PT_KNIGHT  = 3'd3,
    PT_ROOK    = 3'd4,
    PT_BISHOP  = 3'd5,
    PT_QUEEN   = 3'd6,
    PT_KING    = 3'd7
  } piece_type_e;

  typedef enum logic {
    CLR_RED   = 1'b0,
    CLR_BLACK = 1'b1
  } color_e;

  typedef enum logic {
    ST_COVERED   = 1'b0,
    ST_UNCOVERED = 1'b1
  } cover_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_SHUFFLE = 2'd2
  } bs_state_e;

  localparam int unsigned NUM_SQUARES  = 32;
  localparam int unsigned PIECE_W      = 5;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Red occupies squares 0..15, black 16..31; same type order per colour.
  function automatic logic [4:0] canonical_piece(input logic [4:0] sq);
    piece_type_e t;
    case (sq[3:0])
      4'd0:         t = PT_KING;
      4'd1, 4'd2:   t = PT_QUEEN;
      4'd3, 4'd4:   t = PT_BISHOP;
      4'd5, 4'd6:   t = PT_ROOK;
      4'd7, 4'd8:   t = PT_KNIGHT;
      4'd9, 4'd10:  t = PT_CANNON;
      default:      t = PT_SOLDIER;
    endcase
    return {sq[4], t, ST_COVERED};
  endfunction

endpackage

// File: rtl/board_store_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1; a zero seed is replaced by the
// default seed so the register can never lock up.
module lfsr16
  import board_store_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        enable,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)
      q_d = (seed == '0) ? DEFAULT_SEED : seed;
    else if (enable)
      q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) q_q <= DEFAULT_SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/board_store.sv
// 32-square piece store with IDLE writes, a registered display read port and an
// LFSR-driven Fisher-Yates shuffle of the canonical covered layout.
module board_store
  import board_store_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         shuffle_start,
  input  logic [15:0]  seed,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [4:0]   wr_piece,
  input  logic [4:0]   rd_addr,
  output logic [4:0]   rd_piece,
  output logic [159:0] board_flat,
  output logic         busy
);

  bs_state_e   state_q, state_d;
  logic [4:0]  sq_q [NUM_SQUARES];
  logic [4:0]  sq_d [NUM_SQUARES];
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rd_q;
  logic [4:0]  j_w;
  logic [15:0] lfsr_q;
  logic        lfsr_load, lfsr_en;
  logic        unused_lfsr_hi;

  lfsr16 u_lfsr (
    .CLK    (CLK),
    .RESET  (RESET),
    .load   (lfsr_load),
    .seed   (seed),
    .enable (lfsr_en),
    .q      (lfsr_q)
  );

  // Only the low five bits pick the swap partner.
  assign j_w            = lfsr_q[4:0];
  assign unused_lfsr_hi = ^lfsr_q[15:5];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    for (int unsigned k = 0; k < NUM_SQUARES; k++) sq_d[k] = sq_q[k];

    case (state_q)
      S_IDLE: begin
        if (shuffle_start) begin
          state_d   = S_LOAD;
          lfsr_load = 1'b1;
        end else if (wr_en) begin
          sq_d[wr_addr] = wr_piece;
        end
      end
      S_LOAD: begin
        for (int unsigned k = 0; k < NUM_SQUARES; k++) sq_d[k] = canonical_piece(5'(k));
        idx_d   = 5'd31;
        state_d = S_SHUFFLE;
      end
      S_SHUFFLE: begin
        lfsr_en = 1'b1;
        // Out-of-range partner: retry with the next LFSR value, index held.
        if (j_w <= idx_q) begin
          sq_d[idx_q] = sq_q[j_w];
          sq_d[j_w]   = sq_q[idx_q];
          idx_d       = idx_q - 5'd1;
          if (idx_q == 5'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd31;
      rd_q    <= '0;
      for (int unsigned k = 0; k < NUM_SQUARES; k++) sq_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= sq_q[rd_addr];
      for (int unsigned k = 0; k < NUM_SQUARES; k++) sq_q[k] <= sq_d[k];
    end
  end

  always_comb begin
    board_flat = '0;
    for (int unsigned k = 0; k < NUM_SQUARES; k++) board_flat[PIECE_W*k +: PIECE_W] = sq_q[k];
  end

  assign rd_piece = rd_q;
  assign busy     = (state_q != S_IDLE);

endmodule
